add_serial_n: RTL and testbench



---
 rtl/fa_serial_pkg.sv | 14 +
 rtl/fa_1bit.sv | 13 +
 rtl/add_serial_n.sv | 115 +++++++++++
 tb/tb_add_serial_n.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fa_serial_pkg.sv
// Shared types for the bit-serial adder/subtractor: FSM state encoding and
// the add/subtract mode encoding.
package fa_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic ModeAdd = 1'b0;
    localparam logic ModeSub = 1'b1;

endpackage

// File: rtl/fa_1bit.sv
// Single full-adder cell, the only arithmetic in the serial datapath.
module FA_1bit (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/add_serial_n.sv
// Bit-serial n-bit adder/subtractor: one bit per clock, LSB first, through a
// single full-adder cell; (n+1)-bit result with a one-cycle done pulse.
module add_serial_n
    import fa_serial_pkg::*;
#(
    parameter int unsigned n = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [n-1:0] data0_i,
    input  logic [n-1:0] data1_i,
    input  logic         sub_i,
    input  logic         start_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [n:0]   sum_o
);

    localparam int unsigned CntW = $clog2(n);

    state_t          state_q, state_d;
    logic [n-1:0]    a_q, a_d;
    logic [n-1:0]    b_q, b_d;
    logic            carry_q, carry_d;
    logic [n-1:0]    res_q, res_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            mode_q, mode_d;
    logic [n:0]      sum_q, sum_d;

    logic            fa_s;
    logic            fa_co;
    logic [n-1:0]    res_shift;

    FA_1bit u_fa (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .ci_i (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    // New sum bit enters at the MSB; the oldest bit falls off the bottom.
    assign res_shift = n'({fa_s, res_q} >> 1);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        sum_d   = sum_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    // Subtraction as A + ~B + 1: invert B, seed carry with 1.
                    a_d     = data0_i;
                    b_d     = sub_i ? ~data1_i : data1_i;
                    carry_d = sub_i;
                    res_d   = '0;
                    cnt_d   = '0;
                    mode_d  = sub_i;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d   = res_shift;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntW'(n - 1)) begin
                    // In subtract mode the final carry is the inverted borrow.
                    sum_d   = {(mode_q == ModeSub) ? ~fa_co : fa_co, res_shift};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= ModeAdd;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            sum_q   <= sum_d;
        end
    end

    assign busy_o = (state_q == SHIFT);
    assign done_o = (state_q == DONE);
    assign sum_o  = sum_q;

endmodule

// File: tb/tb_add_serial_n.sv
// Self-checking bench for add_serial_n: directed cases, held start, async reset
// mid-operation and randomized back-to-back add/sub against an arithmetic model.
module tb_add_serial_n;

    localparam int unsigned N = 8;
    localparam int unsigned Period = N + 2;

    logic         clk;
    logic         rst;
    logic [N-1:0] data0;
    logic [N-1:0] data1;
    logic         sub;
    logic         start;
    logic         busy;
    logic         done;
    logic [N:0]   sum;

    int checks   = 0;
    int failures = 0;
    logic [N:0] last_sum = '0;
    logic done_prev = 1'b0;

    add_serial_n #(.n(N)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .data0_i (data0),
        .data1_i (data1),
        .sub_i   (sub),
        .start_i (start),
        .busy_o  (busy),
        .done_o  (done),
        .sum_o   (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic.
    function automatic logic [N:0] model(input int unsigned a, input int unsigned b,
                                         input bit s);
        int unsigned m;
        m = (1 << N) - 1;
        if (s) return (N + 1)'(((a < b) ? (1 << N) : 0) | ((a - b) & m));
        return (N + 1)'(a + b);
    endfunction

    // done must never be high in two consecutive cycles.
    always @(negedge clk) begin
        check_eq("done_twice", {31'b0, done & done_prev}, 32'd0);
        done_prev = done;
    end

    // Follow an accepted operation from just after its accepting edge to done.
    task automatic finish_op(input logic [N:0] exp, input string tag);
        for (int k = 1; k <= int'(N); k++) begin
            @(posedge clk);
            #1;
            if (k < int'(N)) begin
                check_eq({tag, "_busy"}, {31'b0, busy}, 32'd1);
                check_eq({tag, "_nodone"}, {31'b0, done}, 32'd0);
                check_eq({tag, "_hold"}, {23'b0, sum}, {23'b0, last_sum});
            end else begin
                check_eq({tag, "_done"}, {31'b0, done}, 32'd1);
                check_eq({tag, "_idle"}, {31'b0, busy}, 32'd0);
                check_eq({tag, "_sum"}, {23'b0, sum}, {23'b0, exp});
            end
        end
        last_sum = exp;
        @(posedge clk);
        #1;
        check_eq({tag, "_pulse"}, {31'b0, done}, 32'd0);
        check_eq({tag, "_keep"}, {23'b0, sum}, {23'b0, last_sum});
    endtask

    task automatic op(input logic [N-1:0] a, input logic [N-1:0] b, input bit s,
                      input string tag);
        @(negedge clk);
        data0 = a;
        data1 = b;
        sub   = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Operand changes after acceptance must not matter.
        data0 = N'($urandom);
        data1 = N'($urandom);
        sub   = 1'($urandom);
        check_eq({tag, "_start"}, {31'b0, busy}, 32'd1);
        finish_op(model(a, b, s), tag);
    endtask

    initial begin
        logic [N:0] exp;
        logic [N-1:0] ra, rb;
        bit rs;

        rst = 1'b1;
        start = 1'b0;
        data0 = '0;
        data1 = '0;
        sub = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_done", {31'b0, done}, 32'd0);
        check_eq("rst_sum", {23'b0, sum}, 32'd0);
        rst = 1'b0;

        op(8'd200, 8'd100, 1'b0, "add_200_100");
        check_eq("const_12c", {23'b0, last_sum}, 32'h12C);
        op(8'd255, 8'd255, 1'b0, "add_255_255");
        check_eq("const_1fe", {23'b0, last_sum}, 32'h1FE);
        op(8'd0, 8'd0, 1'b0, "add_0_0");
        op(8'd100, 8'd30, 1'b1, "sub_100_30");
        check_eq("const_046", {23'b0, last_sum}, 32'h046);
        op(8'd30, 8'd100, 1'b1, "sub_30_100");
        check_eq("const_1ba", {23'b0, last_sum}, 32'h1BA);
        op(8'd77, 8'd77, 1'b1, "sub_77_77");

        // start held high: accepts only every N+2 edges, operands churn each cycle.
        exp = '0;
        for (int e = 0; e < 3 * int'(Period); e++) begin
            @(negedge clk);
            start = 1'b1;
            data0 = N'($urandom);
            data1 = N'($urandom);
            sub   = 1'($urandom);
            @(posedge clk);
            if (e % int'(Period) == 0) exp = model(data0, data1, sub);
            #1;
            check_eq("held_busy", {31'b0, busy}, {31'b0, (e % int'(Period)) < int'(N)});
            check_eq("held_done", {31'b0, done}, {31'b0, (e % int'(Period)) == int'(N)});
            if (done) check_eq("held_sum", {23'b0, sum}, {23'b0, exp});
        end
        last_sum = exp;
        @(negedge clk);
        start = 1'b0;

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        data0 = 8'd12;
        data1 = 8'd34;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_busy", {31'b0, busy}, 32'd0);
        check_eq("arst_done", {31'b0, done}, 32'd0);
        check_eq("arst_sum", {23'b0, sum}, 32'd0);
        last_sum = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < int'(N) + 2; k++) begin
            @(posedge clk);
            #1;
            check_eq("arst_nodone", {31'b0, done | busy}, 32'd0);
        end
        op(8'd150, 8'd151, 1'b1, "post_rst");

        // Release reset while start is already high: accepted on the first edge.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        data0 = 8'd9;
        data1 = 8'd250;
        sub = 1'b0;
        start = 1'b1;
        #1;
        rst = 1'b0;
        last_sum = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("rel_accept", {31'b0, busy}, 32'd1);
        finish_op(model(9, 250, 1'b0), "rel");

        // Randomized back-to-back operations.
        for (int i = 0; i < 1000; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rs = 1'($urandom);
            if (i % 50 == 0) rb = ra;
            op(ra, rb, rs, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
